// File: rtl/bench_1_mon_pkg.sv
// Shared types and default sizing for the bench_1 layer-4 carry monitor.
package bench_1_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ALERT = 2'd2,
      ST_DRAIN = 2'd3
   } mon_state_t;

   localparam int DEF_CNT_W  = 8;
   localparam int DEF_WIN    = 64;
   localparam int DEF_THRESH = 16;

endpackage

// File: rtl/bench_1_sat_cnt.sv
// Saturating event counter with synchronous clear and a full-scale flag.
module bench_1_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk1,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt_upd,
   output logic         sat
);

   localparam logic [W-1:0] CNT_MAX = '1;

   logic [W-1:0] cnt;

   // cnt_upd includes this cycle's event but ignores clr, so the parent can
   // make its clear decision from it without a combinational loop.
   always_comb begin
      cnt_upd = cnt;
      if (inc && (cnt != CNT_MAX)) cnt_upd = cnt + 1'b1;
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else cnt <= cnt_upd;
   end

   assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/bench_1_l4_carry_monitor.sv
// Layer-4 monitor: counts layer-3 carry edges and decode-high cycles per
// window and raises a valid/ack alert when the carry count hits THRESH.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | monitor off, counters held clear
// ST_RUN   | window open, counting carry edges and decode-high cycles
// ST_ALERT | alert pending, latched outputs stable, no counting
// ST_DRAIN | en dropped during RUN, clearing counters before IDLE
module bench_1_l4_carry_monitor
   import bench_1_mon_pkg::*;
#(
   parameter int CNT_W  = DEF_CNT_W,
   parameter int WIN    = DEF_WIN,
   parameter int THRESH = DEF_THRESH
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             en,
   input  logic             n240_in,
   input  logic             x1061_in,
   input  logic             n331_in,
   input  logic             n333_in,
   output logic             alert_valid,
   input  logic             alert_ack,
   output logic [CNT_W-1:0] alert_carry,
   output logic [CNT_W-1:0] alert_hits,
   output logic [1:0]       alert_mode,
   output logic             sat,
   output logic             busy
);

   localparam int               WIN_W    = $clog2(WIN);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);
   localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

   mon_state_t       state, state_nxt;
   logic             n240_q;
   logic             carry_edge;
   logic [WIN_W-1:0] win_cnt;
   logic [CNT_W-1:0] carry_upd, hit_upd;
   logic             carry_sat, hit_sat;
   logic             counting, win_end, alert_go, cnt_clr;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) n240_q <= 1'b0;
      else n240_q <= n240_in;
   end

   assign carry_edge = n240_in & ~n240_q;
   assign counting   = (state == ST_RUN) && en;
   assign win_end    = counting && (win_cnt == WIN_LAST);
   // Threshold uses the count including the final cycle's edge.
   assign alert_go   = win_end && (carry_upd >= THRESH_C);

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (en) state_nxt = ST_RUN;
         ST_RUN: begin
            if (!en) state_nxt = ST_DRAIN;
            else if (alert_go) state_nxt = ST_ALERT;
         end
         ST_ALERT: if (alert_ack) state_nxt = en ? ST_RUN : ST_IDLE;
         ST_DRAIN: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      alert_valid = (state == ST_ALERT);
      busy        = (state != ST_IDLE);
      cnt_clr     = 1'b0;
      case (state)
         ST_IDLE:  cnt_clr = 1'b1;
         ST_RUN:   cnt_clr = !en || (win_end && !alert_go);
         ST_ALERT: cnt_clr = alert_ack;
         ST_DRAIN: cnt_clr = 1'b1;
         default:  cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) win_cnt <= '0;
      else if (!counting || win_end) win_cnt <= '0;
      else win_cnt <= win_cnt + 1'b1;
   end

   bench_1_sat_cnt #(.W(CNT_W)) u_carry_cnt (
      .clk1    (clk1),
      .rst     (rst),
      .clr     (cnt_clr),
      .inc     (counting & carry_edge),
      .cnt_upd (carry_upd),
      .sat     (carry_sat)
   );

   bench_1_sat_cnt #(.W(CNT_W)) u_hit_cnt (
      .clk1    (clk1),
      .rst     (rst),
      .clr     (cnt_clr),
      .inc     (counting & x1061_in),
      .cnt_upd (hit_upd),
      .sat     (hit_sat)
   );

   // Counters hold through ALERT, so sat keeps reporting the latched window.
   assign sat = carry_sat | hit_sat;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         alert_carry <= '0;
         alert_hits  <= '0;
         alert_mode  <= 2'b00;
      end else if (alert_go) begin
         alert_carry <= carry_upd;
         alert_hits  <= hit_upd;
         alert_mode  <= {n333_in, n331_in};
      end
   end

endmodule
